// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM encoding and datapath width for the MDU
package mdu_pkg;
  localparam int DATA_W = 32;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_t;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: 32-step restoring divider on magnitudes with sign fix-up on the outputs
module mdu_div_core import mdu_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              kill,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem,
  output logic              valid
);
  logic [31:0] r_quo, r_rem, r_dvs;
  logic [4:0]  r_cnt;
  logic        r_run, r_sq, r_sr;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_shr;
  logic [33:0] w_diff;
  assign w_abs_a = (sign & dividend[31]) ? -dividend : dividend;
  assign w_abs_b = (sign & divisor[31]) ? -divisor : divisor;
  // partial remainder needs 33 bits after the shift when the divisor exceeds 2^31
  assign w_shr   = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shr} - {2'b0, r_dvs};
  assign quo     = r_sq ? -r_quo : r_quo;
  assign rem     = r_sr ? -r_rem : r_rem;
  // high during the final iteration; quo/rem are final from the following cycle
  assign valid   = r_run & (r_cnt == 5'd31);
  // load magnitudes on start, then one shift/trial-subtract step per cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_sq  <= 1'b0;
      r_sr  <= 1'b0;
    end else if (kill) begin
      r_run <= 1'b0;
    end else if (start) begin
      r_quo <= w_abs_a;
      r_rem <= '0;
      r_dvs <= w_abs_b;
      r_cnt <= '0;
      r_run <= |divisor;
      r_sq  <= sign & (dividend[31] ^ divisor[31]);
      r_sr  <= sign & dividend[31];
    end else if (r_run) begin
      r_quo <= {r_quo[30:0], ~w_diff[33]};
      r_rem <= w_diff[33] ? w_shr[31:0] : w_diff[31:0];
      r_cnt <= r_cnt + 5'd1;
      r_run <= r_cnt != 5'd31;
    end
endmodule

// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: EX-stage mul/div sequencing, pipeline stall and HI/LO ownership
module mdu_hilo_ctrl import mdu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid_i,
  input  logic [2:0]          op_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic                flush_i,
  output logic [DATA_W-1:0]   mul_a_o,
  output logic [DATA_W-1:0]   mul_b_o,
  output logic                mul_sign_o,
  input  logic [2*DATA_W-1:0] mul_result_i,
  output logic                stall_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_mul_a, r_mul_b, r_hi, r_lo, w_quo, w_rem;
  logic              r_mul_sign, r_dz, w_acc, w_is_mul, w_is_div, w_div_last;
  assign w_is_mul   = (op_i == OP_MULT) | (op_i == OP_MULTU);
  assign w_is_div   = (op_i == OP_DIV) | (op_i == OP_DIVU);
  assign w_acc      = op_valid_i & (r_state == S_IDLE) & ~flush_i;
  assign busy_o     = r_state != S_IDLE;
  assign done_o     = ~flush_i & ((r_state == S_MUL) | (r_state == S_DFIX));
  assign stall_o    = (w_acc & (w_is_mul | w_is_div)) | (busy_o & ~done_o);
  assign mul_a_o    = r_mul_a;
  assign mul_b_o    = r_mul_b;
  assign mul_sign_o = r_mul_sign;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  mdu_div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_acc & w_is_div),
    .sign     (op_i == OP_DIV),
    .dividend (a_i),
    .divisor  (b_i),
    .kill     (flush_i),
    .quo      (w_quo),
    .rem      (w_rem),
    .valid    (w_div_last)
  );
  // next state; a zero divisor skips the iterations and goes straight to the fix-up cycle
  always_comb begin
    w_next = flush_i ? S_IDLE :
             (r_state == S_IDLE) ? (!w_acc ? S_IDLE : w_is_mul ? S_MUL :
                                    !w_is_div ? S_IDLE : (|b_i) ? S_DIV : S_DFIX) :
             (r_state == S_DIV) ? (w_div_last ? S_DFIX : S_DIV) : S_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // multiplier operand capture and divide-by-zero marker at issue
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_sign <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      if (w_acc & w_is_mul) begin
        r_mul_a    <= a_i;
        r_mul_b    <= b_i;
        r_mul_sign <= op_i == OP_MULT;
      end
      if (w_acc & w_is_div) r_dz <= ~|b_i;
    end
  // HI/LO update; both halves of a mul/div result land on the same edge, never under flush
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!flush_i) begin
      if (r_state == S_MUL) begin
        r_hi <= mul_result_i[2*DATA_W-1:DATA_W];
        r_lo <= mul_result_i[DATA_W-1:0];
      end else if ((r_state == S_DFIX) & ~r_dz) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else if (w_acc & (op_i == OP_MTHI)) begin
        r_hi <= a_i;
      end else if (w_acc & (op_i == OP_MTLO)) begin
        r_lo <= a_i;
      end
    end
endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb_mdu_hilo_ctrl: scoreboard bench with an arithmetic reference model for HI/LO
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;
  logic        clk = 1'b0, rst = 1'b0, op_valid_i = 1'b0, flush_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [31:0] mul_a_o, mul_b_o, hi_o, lo_o;
  logic        mul_sign_o, stall_o, busy_o, done_o;
  logic [63:0] mul_result_i;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int at;} exp_t;
  exp_t        scb[$];
  exp_t        e;
  logic [31:0] m_hi = '0, m_lo = '0, sh, sl;
  int          checks = 0, failures = 0, cyc = 0;

  mdu_hilo_ctrl dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_sign_o(mul_sign_o),
    .mul_result_i(mul_result_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in for the external combinational multiplier
  always_comb
    mul_result_i = mul_sign_o ? {{32{mul_a_o[31]}}, mul_a_o} * {{32{mul_b_o[31]}}, mul_b_o}
                              : {32'b0, mul_a_o} * {32'b0, mul_b_o};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest expected result, in cycle and value
  always @(negedge clk)
    if (rst && done_o) begin
      if (scb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_o: unexpected pulse got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = scb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.at));
        @(posedge clk);
        #1;
        chk("hi", hi_o, e.hi);
        chk("lo", lo_o, e.lo);
      end
    end

  function automatic logic [31:0] pick();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      default: ;
    endcase
    return v;
  endfunction

  // called at posedge+1; drives one op for one cycle and updates the reference model
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit wait_done);
    int sa, sbv, lat, st, t;
    longint p, q, r;
    logic [63:0] u;
    lat = 0;
    sa = a;
    sbv = b;
    case (op)
      OP_MULT:  begin p = longint'(sa) * longint'(sbv); {m_hi, m_lo} = p; lat = 1; end
      OP_MULTU: begin u = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = u; lat = 1; end
      OP_DIV: begin
        lat = (b == 0) ? 1 : 33;
        if (b != 0) begin
          q = longint'(sa) / longint'(sbv);
          r = longint'(sa) % longint'(sbv);
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      OP_DIVU: begin
        lat = (b == 0) ? 1 : 33;
        if (b != 0) begin
          u = {32'b0, a} / {32'b0, b};
          m_lo = u[31:0];
          u = {32'b0, a} % {32'b0, b};
          m_hi = u[31:0];
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
    t = cyc;
    op_valid_i = 1'b1;
    op_i = op;
    a_i = a;
    b_i = b;
    if (lat > 0) scb.push_back('{m_hi, m_lo, t + lat});
    @(negedge clk);
    chk("stall_issue", 64'(stall_o), 64'(lat > 0));
    @(posedge clk);
    #1;
    op_valid_i = 1'b0;
    if (op == OP_MTHI) chk("mthi", hi_o, m_hi);
    if (op == OP_MTLO) chk("mtlo", lo_o, m_lo);
    if (op == OP_MULT || op == OP_MULTU) begin
      chk("mul_a", mul_a_o, a);
      chk("mul_b", mul_b_o, b);
      chk("mul_sign", 64'(mul_sign_o), 64'(op == OP_MULT));
    end
    if (wait_done && lat > 0) begin
      st = 1;
      for (int n = 0; n < 60 && busy_o; n++) begin
        @(negedge clk);
        if (stall_o) st++;
        @(posedge clk);
        #1;
      end
      chk("stall_cycles", 64'(st), 64'(lat));
      chk("back_to_idle", 64'(busy_o), 64'd0);
    end
  endtask

  initial begin
    #12;
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_mul", {mul_a_o, mul_b_o}, 0);
    chk("rst_flags", {mul_sign_o, stall_o, busy_o, done_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(OP_MULT, 32'hFFFFFFFF, 32'h2, 1);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(OP_DIV, 32'hFFFFFFF9, 32'h2, 1);
    issue(OP_DIVU, 32'd100, 32'h0, 1);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(OP_DIVU, 32'hFFFFFFFF, 32'h1, 1);
    issue(OP_MTHI, 32'h12345678, 32'h0, 0);
    issue(OP_MTLO, 32'h9ABCDEF0, 32'h0, 0);
    // flush in the middle of a divide: op vanishes, HI/LO keep their values
    sh = m_hi;
    sl = m_lo;
    issue(OP_DIV, 32'd12345, 32'd7, 0);
    void'(scb.pop_back());
    m_hi = sh;
    m_lo = sl;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_idle", 64'(busy_o), 64'd0);
    chk("flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    repeat (30) @(posedge clk);
    #1;
    chk("flush_hilo_late", {hi_o, lo_o}, {m_hi, m_lo});
    // asynchronous reset in the middle of a divide
    issue(OP_DIV, 32'd999, 32'd3, 0);
    void'(scb.pop_back());
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("areset_busy", {busy_o, stall_o, done_o}, 0);
    chk("areset_hilo", {hi_o, lo_o}, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(1, 6));
      a = pick();
      b = pick();
      issue(op, a, b, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(scb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
